// File: rtl/hydro_axis_pkg.sv
// Shared types for the hydrophone sample stream: one frame is four 16-bit channel samples,
// sent to the max-finder as two 32-bit AXI-Stream beats.
package hydro_axis_pkg;

    localparam int CH_W    = 16;
    localparam int N_CH    = 4;
    localparam int FRAME_W = CH_W * N_CH;
    localparam int BEAT_W  = 2 * CH_W;

    typedef struct packed {
        logic [CH_W-1:0] ch3;
        logic [CH_W-1:0] ch2;
        logic [CH_W-1:0] ch1;
        logic [CH_W-1:0] ch0;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } tx_state_t;

    function automatic logic [BEAT_W-1:0] beat_lo(input frame_t f);
        return {f.ch1, f.ch0};
    endfunction

    function automatic logic [BEAT_W-1:0] beat_hi(input frame_t f);
        return {f.ch3, f.ch2};
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Small frame FIFO with a combinational head. A push into a full FIFO succeeds only when
// a pop happens at the same edge; the written slot is the one being vacated.
module frame_fifo
    import hydro_axis_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [FRAME_W-1:0]       push_data,
    input  logic                     pop,
    output logic [FRAME_W-1:0]       pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    frame_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= frame_t'(push_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_sample_packer.sv
// AXI-Stream transmitter for 4-channel hydrophone sample sets: buffers sets in a frame FIFO
// and emits each as {ch1,ch0} then {ch3,ch2} with tlast on the second beat.
module axis_sample_packer
    import hydro_axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 4,
    parameter int CNT_W                = 32
) (
    input  logic                              m_axis_aclk,
    input  logic                              m_axis_aresetn,
    input  logic                              smp_valid,
    input  logic [FRAME_W-1:0]                smp_data,
    input  logic                              clear_stats,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  drop_count,
    output logic [CNT_W-1:0]                  frame_count,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    tx_state_t                          state;
    tx_state_t                          next_state;
    logic                               tvalid_q;
    logic                               tvalid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]    tdata_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]    tdata_d;
    logic                               tlast_q;
    logic                               tlast_d;
    logic [BEAT_W-1:0]                  hi_q;
    logic [BEAT_W-1:0]                  hi_d;
    logic                               handshake;
    logic                               frame_done;
    logic                               fifo_pop;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic [FRAME_W-1:0]                 fifo_head;
    frame_t                             head;
    logic                               drop;

    frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m_axis_aclk),
        .rst_n     (m_axis_aresetn),
        .push      (smp_valid),
        .push_data (smp_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign head      = frame_t'(fifo_head);
    assign handshake = tvalid_q && m_axis_tready;
    assign drop      = smp_valid && fifo_full && !fifo_pop;

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state    <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            hi_q     <= '0;
        end else begin
            state    <= next_state;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            hi_q     <= hi_d;
        end
    end

    // Beat0 is loaded straight from the FIFO head; only the upper half is kept for beat1.
    always_comb begin
        next_state = state;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        hi_d       = hi_q;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tdata_d    = beat_lo(head);
                    hi_d       = beat_hi(head);
                    tlast_d    = 1'b0;
                    tvalid_d   = 1'b1;
                    next_state = BEAT0;
                end
            end
            BEAT0: begin
                if (handshake) begin
                    tdata_d    = hi_q;
                    tlast_d    = 1'b1;
                    next_state = BEAT1;
                end
            end
            BEAT1: begin
                if (handshake) begin
                    frame_done = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tdata_d    = beat_lo(head);
                        hi_d       = beat_hi(head);
                        tlast_d    = 1'b0;
                        next_state = BEAT0;
                    end else begin
                        tvalid_d   = 1'b0;
                        tlast_d    = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                tvalid_d   = 1'b0;
                tlast_d    = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // A clear coinciding with a drop still records that one drop in the counter.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            overflow    <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (clear_stats) begin
                overflow   <= 1'b0;
                drop_count <= drop ? CNT_W'(1) : '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
            if (frame_done) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed bench for axis_sample_packer: accepted sample sets go into a scoreboard queue and a
// receiver process rebuilds frames from beat pairs, also checking AXIS stability during stalls.
module tb_axis_sample_packer;

    logic        clk;
    logic        rst_n;
    logic        smp_valid;
    logic [63:0] smp_data;
    logic        clear_stats;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        overflow;
    logic [31:0] drop_count;
    logic [31:0] frame_count;
    logic [2:0]  fifo_level;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] sb [$];

    axis_sample_packer #(
        .C_M_AXIS_TDATA_WIDTH (32),
        .FIFO_DEPTH           (4),
        .CNT_W                (32)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .smp_valid      (smp_valid),
        .smp_data       (smp_data),
        .clear_stats    (clear_stats),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tlast   (tlast),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .frame_count    (frame_count),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; only sets the bench expects to be accepted enter the scoreboard.
    task automatic strobe(input logic [63:0] d, input bit accept);
        smp_valid = 1'b1;
        smp_data  = d;
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    task automatic wait_tvalid(input int budget);
        int n = 0;
        while (!tvalid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("wait_tvalid", 64'(tvalid), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("drain_sb_empty", 64'(sb.size()), 64'd0);
        check_output("drain_tvalid_low", 64'(tvalid), 64'd0);
    endtask

    // Receiver model: stability while stalled, tlast pairing, frame reconstruction.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic        beat_hi    = 1'b0;
    logic [31:0] lo_word    = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            beat_hi    = 1'b0;
            sb.delete();
        end else begin
            if (prev_valid && !prev_ready) begin
                check_output("axis_stable", {31'd0, tvalid, tdata, tlast}, {31'd0, 1'b1, prev_data, prev_last});
            end
            if (tvalid && tready) begin
                check_output("tlast_order", 64'(tlast), 64'(beat_hi));
                if (!beat_hi) begin
                    lo_word = tdata;
                end else if (sb.size() == 0) begin
                    check_output("unexpected_frame", {tdata, lo_word}, 64'hx);
                end else begin
                    check_output("frame_data", {tdata, lo_word}, sb.pop_front());
                end
                beat_hi = ~beat_hi;
            end
            prev_valid = tvalid;
            prev_ready = tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    initial begin
        int hi_cycles;
        rst_n       = 1'b0;
        smp_valid   = 1'b0;
        smp_data    = '0;
        clear_stats = 1'b0;
        tready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_axis", {tvalid, tlast, tdata}, 64'd0);
        check_output("rst_stats", {overflow, drop_count, frame_count}, 64'd0);
        check_output("rst_level", 64'(fifo_level), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame latency and beat layout
        tready = 1'b1;
        strobe(64'h4444_3333_2222_1111, 1'b1);
        check_output("t1_tvalid_n1", 64'(tvalid), 64'd0);
        @(posedge clk);
        #1;
        check_output("t1_tvalid_n2", 64'(tvalid), 64'd1);
        check_output("t1_beat0", {31'd0, tlast, tdata}, {31'd0, 1'b0, 32'h2222_1111});
        @(posedge clk);
        #1;
        check_output("t1_beat1", {31'd0, tlast, tdata}, {31'd0, 1'b1, 32'h4444_3333});
        wait_drain(20);
        check_output("t1_frame_count", 64'(frame_count), 64'd1);

        // Strobe every other cycle: no bubbles once streaming
        hi_cycles = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    strobe({$urandom, $urandom}, 1'b1);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                wait_tvalid(20);
                repeat (40) begin
                    @(negedge clk);
                    if (tvalid) hi_cycles++;
                end
            end
        join
        wait_drain(40);
        check_output("t2_no_bubbles", 64'(hi_cycles), 64'd40);
        check_output("t2_overflow", 64'(overflow), 64'd0);
        check_output("t2_frame_count", 64'(frame_count), 64'd21);

        // Stall: one frame in the output stage, four in the FIFO, last two strobes dropped
        tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe({16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)}, i < 5);
        end
        repeat (23) @(posedge clk);
        #1;
        check_output("t3_level", 64'(fifo_level), 64'd4);
        check_output("t3_overflow", 64'(overflow), 64'd1);
        check_output("t3_drop_count", 64'(drop_count), 64'd2);
        check_output("t3_stalled_valid", 64'(tvalid), 64'd1);

        // Full FIFO with a strobe landing on the beat1 handshake
        tready = 1'b1;
        @(posedge clk);
        #1;
        strobe(64'h0F0F_1E1E_2D2D_3C3C, 1'b1);
        check_output("t4_level", 64'(fifo_level), 64'd4);
        check_output("t4_drop_count", 64'(drop_count), 64'd2);
        wait_drain(40);
        check_output("t4_frame_count", 64'(frame_count), 64'd27);

        // Clear statistics
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        check_output("t6_overflow", 64'(overflow), 64'd0);
        check_output("t6_drop_count", 64'(drop_count), 64'd0);
        check_output("t6_frame_count", 64'(frame_count), 64'd27);

        // Clear coinciding with a drop
        tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clear_stats = (i == 5);
            strobe({$urandom, $urandom}, i < 5);
        end
        clear_stats = 1'b0;
        check_output("t6b_overflow", 64'(overflow), 64'd0);
        check_output("t6b_drop_count", 64'(drop_count), 64'd1);
        tready = 1'b1;
        wait_drain(40);
        check_output("t6b_frame_count", 64'(frame_count), 64'd32);

        // Reset between the beat0 and beat1 handshakes
        tready = 1'b0;
        strobe(64'h1357_9BDF_2468_ACE0, 1'b1);
        wait_tvalid(10);
        tready = 1'b1;
        @(posedge clk);
        #1;
        tready = 1'b0;
        check_output("t5_pending_beat1", 64'(tlast), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_rst_axis", {tvalid, tlast, tdata}, 64'd0);
        check_output("t5_rst_stats", {overflow, drop_count, frame_count}, 64'd0);
        check_output("t5_rst_level", 64'(fifo_level), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        tready = 1'b1;
        strobe(64'h8765_4321_0FED_CBA9, 1'b1);
        @(posedge clk);
        #1;
        check_output("t5_clean_beat0", {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, 1'b0, 32'h0FED_CBA9});
        wait_drain(20);
        check_output("t5_frame_count", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
